// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus: step request, instruction memory port and decoded fields.
// The master modport is the environment side; slave is the fetch unit.
interface instr_fetch_decode_if;
    logic        i_Step;
    logic [15:0] i_INSTR;
    logic [7:0]  o_PC;
    logic [15:0] o_IR;
    logic [3:0]  o_Opcode;
    logic [3:0]  o_Rd;
    logic [3:0]  o_Rs;
    logic [3:0]  o_Rt;
    logic [7:0]  o_Imm8;
    logic        o_Valid;
    logic        o_Busy;
    logic        o_Halt;

    modport master (
        output i_Step, i_INSTR,
        input  o_PC, o_IR, o_Opcode, o_Rd, o_Rs, o_Rt, o_Imm8, o_Valid, o_Busy, o_Halt
    );

    modport slave (
        input  i_Step, i_INSTR,
        output o_PC, o_IR, o_Opcode, o_Rd, o_Rs, o_Rt, o_Imm8, o_Valid, o_Busy, o_Halt
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Single-step instruction fetch and decode: each rising step edge fetches one word
// from a synchronous instruction memory, latches it into the IR and advances the PC.
module instr_fetch_decode #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [3:0] JUMP_OPCODE = 4'hE
) (
    input  logic                       i_CLK,
    input  logic                       i_RESET,
    instr_fetch_decode_if.slave        fd_io
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        step_q;
    logic        step_edge;
    logic [3:0]  fetched_op;

    assign step_edge  = fd_io.i_Step & ~step_q;
    assign fetched_op = fd_io.i_INSTR[15:12];

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= StIdle;
            pc_q    <= 8'h00;
            ir_q    <= 16'h0000;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            step_q  <= fd_io.i_Step;
        end
    end

    // Memory samples pc_q at the FETCH edge; its data is captured at the WAIT edge,
    // so the PC must not move until the capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step_edge) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                ir_d    = fd_io.i_INSTR;
                valid_d = 1'b1;
                if (fetched_op == HALT_OPCODE) begin
                    state_d = StHalt;
                end else begin
                    state_d = StIdle;
                    if (fetched_op == JUMP_OPCODE) begin
                        pc_d = fd_io.i_INSTR[7:0];
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fd_io.o_PC     = pc_q;
    assign fd_io.o_IR     = ir_q;
    assign fd_io.o_Opcode = ir_q[15:12];
    assign fd_io.o_Rd     = ir_q[11:8];
    assign fd_io.o_Rs     = ir_q[7:4];
    assign fd_io.o_Rt     = ir_q[3:0];
    assign fd_io.o_Imm8   = ir_q[7:0];
    assign fd_io.o_Valid  = valid_q;
    assign fd_io.o_Busy   = (state_q == StFetch) || (state_q == StWait);
    assign fd_io.o_Halt   = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: table of fetches plus hand-written
// sequences for ignored steps, halt and reset corner cases.
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    logic [15:0] mem [256];

    instr_fetch_decode_if fd_if ();

    instr_fetch_decode #(
        .HALT_OPCODE(4'hF),
        .JUMP_OPCODE(4'hE)
    ) dut (
        .i_CLK  (clk),
        .i_RESET(rst),
        .fd_io  (fd_if)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid one cycle after the address.
    always @(posedge clk) fd_if.i_INSTR <= mem[fd_if.o_PC];

    always @(negedge clk) if (fd_if.o_Valid) valid_cnt++;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        logic [7:0]  exp_pc;
        logic [3:0]  exp_op;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_rs;
        logic [3:0]  exp_rt;
        logic [7:0]  exp_imm;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fd_if.i_Step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        fd_if.i_Step = 1'b1;
        @(negedge clk);
        fd_if.i_Step = 1'b0;
    endtask

    task automatic fetch_vec(input vec_t v);
        logic [7:0] pc0;
        int lat;
        bit seen;
        @(negedge clk);
        pc0 = fd_if.o_PC;
        check("fetch_addr", {24'h0, pc0}, {24'h0, v.addr});
        fd_if.i_Step = 1'b1;
        @(posedge clk); #1;
        fd_if.i_Step = 1'b0;
        check("busy_after_step", {31'h0, fd_if.o_Busy}, 32'h1);
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (fd_if.o_Valid) seen = 1'b1;
            else check("pc_hold", {24'h0, fd_if.o_PC}, {24'h0, pc0});
        end
        check("valid_latency", lat, 3);
        check("ir", {16'h0, fd_if.o_IR}, {16'h0, v.word});
        check("pc_next", {24'h0, fd_if.o_PC}, {24'h0, v.exp_pc});
        check("opcode", {28'h0, fd_if.o_Opcode}, {28'h0, v.exp_op});
        check("rd", {28'h0, fd_if.o_Rd}, {28'h0, v.exp_rd});
        check("rs", {28'h0, fd_if.o_Rs}, {28'h0, v.exp_rs});
        check("rt", {28'h0, fd_if.o_Rt}, {28'h0, v.exp_rt});
        check("imm8", {24'h0, fd_if.o_Imm8}, {24'h0, v.exp_imm});
        check("busy_done", {31'h0, fd_if.o_Busy}, 32'h0);
        check("halt_low", {31'h0, fd_if.o_Halt}, 32'h0);
        @(posedge clk); #1;
        check("valid_one_cycle", {31'h0, fd_if.o_Valid}, 32'h0);
    endtask

    initial begin
        int base;
        vecs[0] = '{8'h00, 16'h1234, 8'h01, 4'h1, 4'h2, 4'h3, 4'h4, 8'h34};
        vecs[1] = '{8'h01, 16'hE07F, 8'h7F, 4'hE, 4'h0, 4'h7, 4'hF, 8'h7F};
        vecs[2] = '{8'h7F, 16'h5A10, 8'h80, 4'h5, 4'hA, 4'h1, 4'h0, 8'h10};
        vecs[3] = '{8'h80, 16'hE0FF, 8'hFF, 4'hE, 4'h0, 4'hF, 4'hF, 8'hFF};
        vecs[4] = '{8'hFF, 16'h3C96, 8'h00, 4'h3, 4'hC, 4'h9, 4'h6, 8'h96};
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 5; i++) mem[vecs[i].addr] = vecs[i].word;

        do_reset();
        #1;
        check("rst_pc", {24'h0, fd_if.o_PC}, 32'h0);
        check("rst_ir", {16'h0, fd_if.o_IR}, 32'h0);
        check("rst_valid", {31'h0, fd_if.o_Valid}, 32'h0);
        check("rst_busy", {31'h0, fd_if.o_Busy}, 32'h0);
        check("rst_halt", {31'h0, fd_if.o_Halt}, 32'h0);

        // Sequential, jump, jump to 0xFF, wrap to 0x00.
        for (int i = 0; i < 5; i++) fetch_vec(vecs[i]);

        // Second edge while busy is dropped: PC 00 -> 01, one valid.
        base = valid_cnt;
        @(negedge clk); fd_if.i_Step = 1'b1;
        @(negedge clk); fd_if.i_Step = 1'b0;
        @(negedge clk); fd_if.i_Step = 1'b1;
        @(negedge clk); fd_if.i_Step = 1'b0;
        repeat (6) @(negedge clk);
        check("ignore_busy_cnt", valid_cnt - base, 1);
        check("ignore_busy_pc", {24'h0, fd_if.o_PC}, 32'h01);

        // Edge at k+3 is accepted: two fetches 01 -> 7F -> 80.
        base = valid_cnt;
        @(negedge clk); fd_if.i_Step = 1'b1;
        @(negedge clk); fd_if.i_Step = 1'b0;
        @(negedge clk);
        @(negedge clk); fd_if.i_Step = 1'b1;
        @(negedge clk); fd_if.i_Step = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_cnt", valid_cnt - base, 2);
        check("b2b_pc", {24'h0, fd_if.o_PC}, 32'h80);

        // Held step gives one fetch: 80 -> FF.
        base = valid_cnt;
        @(negedge clk); fd_if.i_Step = 1'b1;
        repeat (100) @(negedge clk);
        fd_if.i_Step = 1'b0;
        repeat (4) @(negedge clk);
        check("held_cnt", valid_cnt - base, 1);
        check("held_pc", {24'h0, fd_if.o_PC}, 32'hFF);

        // Halt.
        do_reset();
        mem[0] = 16'hF000;
        base = valid_cnt;
        pulse_step();
        repeat (4) @(negedge clk);
        check("halt_cnt", valid_cnt - base, 1);
        check("halt_flag", {31'h0, fd_if.o_Halt}, 32'h1);
        check("halt_pc", {24'h0, fd_if.o_PC}, 32'h00);
        check("halt_ir", {16'h0, fd_if.o_IR}, 32'hF000);
        check("halt_busy", {31'h0, fd_if.o_Busy}, 32'h0);
        mem[0] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            repeat (3) @(negedge clk);
        end
        check("halt_no_valid", valid_cnt - base, 1);
        check("halt_ir_frozen", {16'h0, fd_if.o_IR}, 32'hF000);
        check("halt_pc_frozen", {24'h0, fd_if.o_PC}, 32'h00);
        #1 rst = 1'b1;
        #1;
        check("halt_rst_flag", {31'h0, fd_if.o_Halt}, 32'h0);
        check("halt_rst_pc", {24'h0, fd_if.o_PC}, 32'h00);
        check("halt_rst_ir", {16'h0, fd_if.o_IR}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Reset while in WAIT aborts the fetch asynchronously.
        base = valid_cnt;
        @(negedge clk); fd_if.i_Step = 1'b1;
        @(posedge clk); #1; fd_if.i_Step = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_before", {31'h0, fd_if.o_Busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_busy", {31'h0, fd_if.o_Busy}, 32'h0);
        check("mid_ir", {16'h0, fd_if.o_IR}, 32'h0);
        check("mid_valid", {31'h0, fd_if.o_Valid}, 32'h0);
        repeat (3) @(negedge clk);
        check("mid_no_valid", valid_cnt - base, 0);

        // Step high at reset release counts as an edge on the first clock.
        fd_if.i_Step = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        fd_if.i_Step = 1'b0;
        check("rel_step_cnt", valid_cnt - base, 1);
        check("rel_step_ir", {16'h0, fd_if.o_IR}, 32'h1234);
        check("rel_step_pc", {24'h0, fd_if.o_PC}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
